// File: rtl/fma_pkg.sv
// fma_pkg
//   Shared definitions for the Q1.15 fma unit and its dispatch sequencer:
//   fma core_state pin encodings, Q1.15 saturation limits and the
//   dispatch FSM state type.
package fma_pkg;

   // fma core_state pin encodings
   localparam logic [2:0] CORE_IDLE    = 3'b000;
   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_EXECUTE = 3'b101;

   // Q1.15 saturation limits applied inside the fma
   localparam logic [15:0] Q115_MAX = 16'h7FFF;
   localparam logic [15:0] Q115_MIN = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_REQUEST,
      ST_EXEC1,
      ST_EXEC2,
      ST_CAPTURE,
      ST_RESULT
   } dispatch_state_e;

endpackage

// File: rtl/fma_dispatch_if.sv
// fma_dispatch_if
//   Operand stream and result stream of the dot-product dispatcher.
//   op_*  : activation/weight pairs, valid/ready
//   res_* : final Q1.15 sum, valid/ready
//   master : the environment (operand source, result consumer)
//   slave  : the dispatcher
interface fma_dispatch_if #(
   parameter int DATA_BITS = 16
);
   logic                 op_valid;
   logic                 op_ready;
   logic [DATA_BITS-1:0] op_act;
   logic [DATA_BITS-1:0] op_wgt;
   logic                 res_valid;
   logic                 res_ready;
   logic [DATA_BITS-1:0] res_data;

   modport master (
      output op_valid, op_act, op_wgt, res_ready,
      input  op_ready, res_valid, res_data
   );

   modport slave (
      input  op_valid, op_act, op_wgt, res_ready,
      output op_ready, res_valid, res_data
   );
endinterface

// File: rtl/fma_dispatch.sv
// fma_dispatch
//   Initiator-side sequencer for one Q1.15 fma instance. Takes a start
//   command (vector length, initial accumulator), pulls operand pairs over
//   sif.op_*, runs one fma step per pair (REQUEST, EXEC1, EXEC2) and feeds
//   the saturated fma result back as the next accumulator. The final sum is
//   offered on sif.res_*. No arithmetic here beyond the pair counter.
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   start/vec_len/init_acc : command, sampled only in IDLE
//   busy                : high outside IDLE
//   sif (slave)         : operand stream in, result stream out
//   fma_enable, fma_core_state, fma_decoded_enable,
//   fma_rs/rt/rq        : fma pin drive
//   fma_out             : fma registered result
module fma_dispatch
   import fma_pkg::*;
#(
   parameter int DATA_BITS = 16,
   parameter int LEN_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_BITS-1:0]  vec_len,
   input  logic [DATA_BITS-1:0] init_acc,
   output logic                 busy,
   fma_dispatch_if.slave        sif,
   output logic                 fma_enable,
   output logic [2:0]           fma_core_state,
   output logic                 fma_decoded_enable,
   output logic [DATA_BITS-1:0] fma_rs,
   output logic [DATA_BITS-1:0] fma_rt,
   output logic [DATA_BITS-1:0] fma_rq,
   input  logic [DATA_BITS-1:0] fma_out
);

   dispatch_state_e      state_q, state_d;
   logic [DATA_BITS-1:0] acc_q, acc_d;
   logic [DATA_BITS-1:0] act_q, act_d;
   logic [DATA_BITS-1:0] wgt_q, wgt_d;
   logic [LEN_BITS-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         act_q   <= '0;
         wgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         act_q   <= act_d;
         wgt_q   <= wgt_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      act_d   = act_q;
      wgt_d   = wgt_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = init_acc;
               cnt_d   = vec_len;
               state_d = (vec_len == '0) ? ST_RESULT : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (sif.op_valid) begin
               act_d   = sif.op_act;
               wgt_d   = sif.op_wgt;
               state_d = ST_REQUEST;
            end
         end
         ST_REQUEST: state_d = ST_EXEC1;
         ST_EXEC1:   state_d = ST_EXEC2;
         ST_EXEC2:   state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            // fma_out was registered by the fma on the EXEC2 edge
            acc_d   = fma_out;
            cnt_d   = cnt_q - LEN_BITS'(1);
            // compare before the decrement so vec_len of all-ones never wraps
            state_d = (cnt_q == LEN_BITS'(1)) ? ST_RESULT : ST_FETCH;
         end
         ST_RESULT: begin
            if (sif.res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fma_core_state     = CORE_IDLE;
      fma_decoded_enable = 1'b0;
      case (state_q)
         ST_REQUEST: fma_core_state = CORE_REQUEST;
         ST_EXEC1, ST_EXEC2: begin
            fma_core_state     = CORE_EXECUTE;
            fma_decoded_enable = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy          = (state_q != ST_IDLE);
   assign fma_enable    = busy;
   assign fma_rs        = act_q;
   assign fma_rt        = wgt_q;
   assign fma_rq        = acc_q;
   assign sif.op_ready  = (state_q == ST_FETCH);
   assign sif.res_valid = (state_q == ST_RESULT);
   assign sif.res_data  = acc_q;

endmodule
